// File: rtl/sd_sinc_filter.sv
// Decimating sinc1/2/3 (CIC) filter for the sigma-delta bitstream, one clock domain (SYSCLK).
// Optional threshold comparator on the result is compiled in with `define SDFM_FLT_CMP_EN.
module sd_sinc_filter #(
    parameter int DATA_W  = 25,
    parameter int SYNC_ST = 2
) (
    input  logic              SYSRSTn,
    input  logic              SYSCLK,
    input  logic              sd_dsd_in,
    input  logic              sd_clk_in,
    input  logic              sd_err,
    input  logic              reg_fen,
    input  logic [1:0]        reg_ford,
    input  logic [7:0]        reg_fosr,
    input  logic [DATA_W-1:0] reg_cmph,
    input  logic [DATA_W-1:0] reg_cmpl,
    output logic [DATA_W-1:0] flt_data,
    output logic              flt_ready,
    output logic              cmp_hi,
    output logic              cmp_lo
);

    logic [SYNC_ST-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_ST-1:0] dsd_sync_q, dsd_sync_d;
    logic               clk_edge_q, clk_edge_d;
    logic               strobe;
    logic               sample_bit;
    logic               clear;
    logic [1:0]         order;

    logic [7:0]         cnt_q, cnt_d;
    logic               dec_q, dec_d;
    logic [DATA_W-1:0]  i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [DATA_W-1:0]  p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [DATA_W-1:0]  tap, c1, c2, c3, result;
    logic [1:0]         settle_q, settle_d;
    logic               emit;

    logic [DATA_W-1:0]  flt_data_q, flt_data_d;
    logic               flt_ready_q, flt_ready_d;
    logic               cmp_hi_q, cmp_hi_d;
    logic               cmp_lo_q, cmp_lo_d;

    always_comb begin
        clk_sync_d = (clk_sync_q << 1) | SYNC_ST'(sd_clk_in);
        dsd_sync_d = (dsd_sync_q << 1) | SYNC_ST'(sd_dsd_in);
        clk_edge_d = clk_sync_q[SYNC_ST-1];
    end

    // A rising edge of the synchronized sample clock is one sample; data is taken on that cycle.
    assign strobe     = clk_sync_q[SYNC_ST-1] & ~clk_edge_q;
    assign sample_bit = dsd_sync_q[SYNC_ST-1];
    assign clear      = ~reg_fen | sd_err;

    always_comb begin
        case (reg_ford)
            2'b00:   order = 2'd1;
            2'b01:   order = 2'd2;
            default: order = 2'd3;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        dec_d = 1'b0;
        i1_d  = i1_q;
        i2_d  = i2_q;
        i3_d  = i3_q;
        if (clear) begin
            cnt_d = '0;
            i1_d  = '0;
            i2_d  = '0;
            i3_d  = '0;
        end else if (strobe) begin
            i1_d = i1_q + {{(DATA_W-1){1'b0}}, sample_bit};
            i2_d = i2_q + i1_q;
            i3_d = i3_q + i2_q;
            if (cnt_q >= reg_fosr) begin
                cnt_d = '0;
                dec_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        case (order)
            2'd1:    tap = i1_q;
            2'd2:    tap = i2_q;
            default: tap = i3_q;
        endcase
        c1 = tap - p1_q;
        c2 = c1 - p2_q;
        c3 = c2 - p3_q;
        case (order)
            2'd1:    result = c1;
            2'd2:    result = c2;
            default: result = c3;
        endcase
    end

    assign emit = dec_q & ~clear & (settle_q >= order);

    // The first `order` decimations only prime the comb history and are not reported.
    always_comb begin
        p1_d        = p1_q;
        p2_d        = p2_q;
        p3_d        = p3_q;
        settle_d    = settle_q;
        flt_data_d  = flt_data_q;
        flt_ready_d = 1'b0;
        if (clear) begin
            p1_d     = '0;
            p2_d     = '0;
            p3_d     = '0;
            settle_d = '0;
        end else if (dec_q) begin
            p1_d = tap;
            if (order >= 2'd2) p2_d = c1;
            if (order == 2'd3) p3_d = c2;
            if (settle_q < order) begin
                settle_d = settle_q + 2'd1;
            end else begin
                flt_data_d  = result;
                flt_ready_d = 1'b1;
            end
        end
    end

`ifdef SDFM_FLT_CMP_EN
    always_comb begin
        cmp_hi_d = cmp_hi_q;
        cmp_lo_d = cmp_lo_q;
        if (clear) begin
            cmp_hi_d = 1'b0;
            cmp_lo_d = 1'b0;
        end else if (emit) begin
            cmp_hi_d = result > reg_cmph;
            cmp_lo_d = result < reg_cmpl;
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = ^{reg_cmph, reg_cmpl, emit};

    always_comb begin
        cmp_hi_d = 1'b0;
        cmp_lo_d = 1'b0;
    end
`endif

    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            clk_sync_q  <= '0;
            dsd_sync_q  <= '0;
            clk_edge_q  <= 1'b0;
            cnt_q       <= '0;
            dec_q       <= 1'b0;
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            p3_q        <= '0;
            settle_q    <= '0;
            flt_data_q  <= '0;
            flt_ready_q <= 1'b0;
            cmp_hi_q    <= 1'b0;
            cmp_lo_q    <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dsd_sync_q  <= dsd_sync_d;
            clk_edge_q  <= clk_edge_d;
            cnt_q       <= cnt_d;
            dec_q       <= dec_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            p3_q        <= p3_d;
            settle_q    <= settle_d;
            flt_data_q  <= flt_data_d;
            flt_ready_q <= flt_ready_d;
            cmp_hi_q    <= cmp_hi_d;
            cmp_lo_q    <= cmp_lo_d;
        end
    end

    assign flt_data  = flt_data_q;
    assign flt_ready = flt_ready_q;
    assign cmp_hi    = cmp_hi_q;
    assign cmp_lo    = cmp_lo_q;

endmodule

// File: tb/tb_sd_sinc_filter.sv
// Directed bench for sd_sinc_filter: cycle-exact sample streams with hand-computed CIC results.
// Comparator expectations follow SDFM_FLT_CMP_EN as defined for the build.
module tb_sd_sinc_filter;

    localparam int DATA_W  = 25;
    localparam int SYNC_ST = 2;
`ifdef SDFM_FLT_CMP_EN
    localparam logic [31:0] CMP_EN = 32'd1;
`else
    localparam logic [31:0] CMP_EN = 32'd0;
`endif

    logic              SYSCLK;
    logic              SYSRSTn;
    logic              sd_dsd_in;
    logic              sd_clk_in;
    logic              sd_err;
    logic              reg_fen;
    logic [1:0]        reg_ford;
    logic [7:0]        reg_fosr;
    logic [DATA_W-1:0] reg_cmph;
    logic [DATA_W-1:0] reg_cmpl;
    logic [DATA_W-1:0] flt_data;
    logic              flt_ready;
    logic              cmp_hi;
    logic              cmp_lo;

    int tests_run       = 0;
    int tests_failed    = 0;
    int cyc             = 0;
    int ready_count     = 0;
    int last_ready_cyc  = 0;
    int prev_ready_cyc  = 0;
    int last_sample_cyc = 0;
    int rc0;
    logic [DATA_W-1:0] last_ready_data = '0;

    sd_sinc_filter #(
        .DATA_W (DATA_W),
        .SYNC_ST(SYNC_ST)
    ) dut (
        .SYSRSTn  (SYSRSTn),
        .SYSCLK   (SYSCLK),
        .sd_dsd_in(sd_dsd_in),
        .sd_clk_in(sd_clk_in),
        .sd_err   (sd_err),
        .reg_fen  (reg_fen),
        .reg_ford (reg_ford),
        .reg_fosr (reg_fosr),
        .reg_cmph (reg_cmph),
        .reg_cmpl (reg_cmpl),
        .flt_data (flt_data),
        .flt_ready(flt_ready),
        .cmp_hi   (cmp_hi),
        .cmp_lo   (cmp_lo)
    );

    initial begin
        SYSCLK = 1'b0;
        forever #5 SYSCLK = ~SYSCLK;
    end

    initial begin
        forever begin
            @(posedge SYSCLK);
            cyc++;
        end
    end

    // Records every ready pulse so batches can be checked after the stream ends.
    initial begin
        forever begin
            @(negedge SYSCLK);
            if (flt_ready === 1'b1) begin
                ready_count++;
                prev_ready_cyc  = last_ready_cyc;
                last_ready_cyc  = cyc;
                last_ready_data = flt_data;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // pattern: 0 = all zeros, 1 = all ones, 2 = alternating starting with 1.
    task automatic applyStimulus(input int n, input int period, input bit strobe_mode, input int pattern);
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < period; k++) begin
                @(posedge SYSCLK);
                #1;
                if (k == 0) begin
                    case (pattern)
                        0:       sd_dsd_in = 1'b0;
                        1:       sd_dsd_in = 1'b1;
                        default: sd_dsd_in = (s % 2 == 0);
                    endcase
                    last_sample_cyc = cyc;
                end
                sd_clk_in = strobe_mode ? (k == 0) : (k < period / 2);
            end
        end
        repeat (6) @(posedge SYSCLK);
        #1;
    endtask

    task automatic checkBatch(input string tag, input int exp_readies, input logic [31:0] exp_data);
        checkOutput({tag, "_count"}, ready_count - rc0, exp_readies);
        checkOutput({tag, "_data"}, last_ready_data, exp_data);
        checkOutput({tag, "_latency"}, last_ready_cyc - last_sample_cyc, SYNC_ST + 2);
    endtask

    initial begin
        SYSRSTn   = 1'b0;
        sd_dsd_in = 1'b0;
        sd_clk_in = 1'b0;
        sd_err    = 1'b0;
        reg_fen   = 1'b0;
        reg_ford  = 2'b10;
        reg_fosr  = 8'd31;
        reg_cmph  = 25'h7FFF;
        reg_cmpl  = 25'h10;
        repeat (3) @(posedge SYSCLK);
        #1;
        checkOutput("reset_data", flt_data, 0);
        checkOutput("reset_ready", flt_ready, 0);
        checkOutput("reset_cmp_hi", cmp_hi, 0);
        checkOutput("reset_cmp_lo", cmp_lo, 0);
        SYSRSTn = 1'b1;
        repeat (2) @(posedge SYSCLK);
        #1;
        reg_fen = 1'b1;
        repeat (3) @(posedge SYSCLK);
        #1;

        // sinc3, OSR 32, ones at SYSCLK/8: six decimations, first three suppressed.
        rc0 = ready_count;
        applyStimulus(192, 8, 1'b0, 1);
        checkBatch("sinc3_ones", 3, 32'h8000);
        checkOutput("sinc3_ones_interval", last_ready_cyc - prev_ready_cyc, 256);
        checkOutput("sinc3_ones_cmp_hi", cmp_hi, CMP_EN);
        checkOutput("sinc3_ones_cmp_lo", cmp_lo, 0);

        rc0 = ready_count;
        applyStimulus(160, 8, 1'b0, 0);
        checkBatch("sinc3_zeros", 5, 0);
        checkOutput("sinc3_zeros_cmp_hi", cmp_hi, 0);
        checkOutput("sinc3_zeros_cmp_lo", cmp_lo, CMP_EN);

        rc0 = ready_count;
        applyStimulus(160, 8, 1'b0, 1);
        checkBatch("sinc3_ones_again", 5, 32'h8000);

        // Error arrives mid-decimation; everything restarts from zero afterwards.
        applyStimulus(16, 8, 1'b0, 1);
        rc0 = ready_count;
        sd_err = 1'b1;
        repeat (5) @(posedge SYSCLK);
        #1;
        checkOutput("err_data_hold", flt_data, 32'h8000);
        checkOutput("err_cmp_hi", cmp_hi, 0);
        repeat (5) @(posedge SYSCLK);
        #1;
        sd_err = 1'b0;
        checkOutput("err_no_ready", ready_count - rc0, 0);
        rc0 = ready_count;
        applyStimulus(128, 8, 1'b0, 1);
        checkBatch("err_recover", 1, 32'h8000);
        checkOutput("err_recover_cmp_hi", cmp_hi, CMP_EN);

        reg_fen = 1'b0;
        repeat (2) @(posedge SYSCLK);
        #1;
        checkOutput("disable_ready", flt_ready, 0);
        checkOutput("disable_data_hold", flt_data, 32'h8000);
        checkOutput("disable_cmp_hi", cmp_hi, 0);

        // sinc1, OSR 16, alternating bits on one-cycle strobes every 4 SYSCLK.
        reg_ford = 2'b00;
        reg_fosr = 8'd15;
        reg_fen  = 1'b1;
        repeat (2) @(posedge SYSCLK);
        #1;
        rc0 = ready_count;
        applyStimulus(64, 4, 1'b1, 2);
        checkBatch("sinc1_alt", 3, 8);
        checkOutput("sinc1_alt_interval", last_ready_cyc - prev_ready_cyc, 64);
        checkOutput("sinc1_alt_cmp_lo", cmp_lo, CMP_EN);

        // OSR 1 boundary: every sample is a decimation.
        reg_fen  = 1'b0;
        reg_fosr = 8'd0;
        repeat (2) @(posedge SYSCLK);
        #1;
        reg_fen = 1'b1;
        rc0 = ready_count;
        applyStimulus(6, 2, 1'b0, 1);
        checkBatch("osr1", 5, 1);
        checkOutput("osr1_interval", last_ready_cyc - prev_ready_cyc, 2);

        // sinc2, OSR 256: zeros, then ones after disable/re-enable.
        reg_fen  = 1'b0;
        reg_ford = 2'b01;
        reg_fosr = 8'd255;
        repeat (2) @(posedge SYSCLK);
        #1;
        reg_fen = 1'b1;
        rc0 = ready_count;
        applyStimulus(768, 2, 1'b0, 0);
        checkBatch("sinc2_zeros", 1, 0);
        reg_fen = 1'b0;
        repeat (2) @(posedge SYSCLK);
        #1;
        reg_fen = 1'b1;
        rc0 = ready_count;
        applyStimulus(768, 2, 1'b0, 1);
        checkBatch("sinc2_ones", 1, 65536);
        checkOutput("sinc2_ones_cmp_hi", cmp_hi, CMP_EN);

        // Asynchronous reset in the middle of a decimation.
        applyStimulus(100, 2, 1'b0, 1);
        @(posedge SYSCLK);
        #3;
        SYSRSTn = 1'b0;
        #1;
        checkOutput("async_reset_data", flt_data, 0);
        checkOutput("async_reset_ready", flt_ready, 0);
        checkOutput("async_reset_cmp_hi", cmp_hi, 0);
        repeat (2) @(posedge SYSCLK);
        #1;
        SYSRSTn = 1'b1;
        repeat (2) @(posedge SYSCLK);
        #1;
        rc0 = ready_count;
        applyStimulus(768, 2, 1'b0, 1);
        checkBatch("after_reset", 1, 65536);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
